wb_arbiter: RTL and testbench
=============================

Name: wb_arbiter

Overview:
- Write-back stage directly upstream of the 32x32 register file.
- Accepts completed results from two producers: the ALU/execute path and the load/memory path.
- Each source gets a one-entry holding slot. The two slots are arbitrated onto the register file's single write port (reg_wren / w_reg0 / w_data) at one write per cycle.
- Exports a pending-destination bitmap so decode can stall on RAW hazards against writes not yet committed.

Parameters:
- DATA_W, 32, result/write-data width.
- ADDR_W, 5, register index width (32 registers).
- RR_EN, 1, 1 = round-robin between sources when both slots are full; 0 = fixed ALU priority.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- alu_valid  in  1  ALU result offered.
- alu_ready  out  1  ALU slot can accept this cycle.
- alu_rd  in  ADDR_W  ALU destination register.
- alu_data  in  DATA_W  ALU result.
- mem_valid  in  1  load result offered.
- mem_ready  out  1  load slot can accept this cycle.
- mem_rd  in  ADDR_W  load destination register.
- mem_data  in  DATA_W  load result.
- reg_wren  out  1  register file write enable (registered).
- w_reg0  out  ADDR_W  register file write select (registered).
- w_data  out  DATA_W  register file write data (registered).
- pending  out  32  bit i = 1 while a write to register i is held or being driven; bit 0 always 0.

Behaviour:
- One clock (clk); reset is asynchronous, active-low (reset_n), fixed.
- Reset values:
  - reg_wren=0, w_reg0=0, w_data=0.
  - Both slots empty.
  - pending=0.
  - last_grant=MEM, so the ALU wins the first contested cycle.
  - alu_ready=mem_ready=1 immediately after reset deasserts.
- Handshake:
  - A transfer occurs on a rising edge where valid && ready.
  - ready = slot empty || slot granted this cycle. Same-cycle drain and refill is allowed, giving full throughput for one source.
  - ready must not depend combinationally on valid.
  - Payload is captured only on a transfer; valid without ready is held by the producer.
- rd==0 discard: a transfer with rd==0 is accepted and dropped. The slot is not loaded, no write is issued, and the write port is not consumed.
- Arbitration (combinational from slot state, each cycle):
  - Only one slot full: grant it.
  - Both full, RR_EN=1: grant the source opposite last_grant, then update last_grant.
  - Both full, RR_EN=0: grant ALU always.
  - Neither full: no grant.
- Output register:
  - On grant: reg_wren<=1, w_reg0<=slot.rd, w_data<=slot.data, and the slot empties unless refilled on the same edge.
  - No grant: reg_wren<=0; w_reg0 and w_data hold their last values.
- Latency (uncontested): accepted at edge E, reg_wren high in the cycle after edge E+1, regfile commits at edge E+2. A contested entry waits one extra cycle per lost arbitration; maximum wait is 1 cycle with RR_EN=1.
- pending: OR of decoded rd for each full slot and (reg_wren ? w_reg0). Purely combinational from registers. Bit 0 forced to 0.
- Ordering:
  - Within one source, results are written in acceptance order.
  - Across sources there is no ordering guarantee. Decode must not issue a second writer to a register whose pending bit is set.
  - Both slots holding the same rd is a protocol violation; the bench asserts it never occurs.
- Reset mid-operation: slot contents discarded, outputs cleared on assertion without waiting for clk, no partial write.

Decomposition:
- Shared package wb_pkg:
  - Source IDs SRC_ALU=0, SRC_MEM=1.
  - Default widths DATA_W/ADDR_W.
  - Register index REG_ZERO=0.
- Sub-module wb_slot: one-entry valid/ready holding register with rd/data, a grant input and a full output. Instantiated twice.
- Top-level contents: arbiter, last_grant flop, output register and pending decode.

Test Plan:
- ALU-only stream: ALU sends (rd=8,data=0x11111111) at edge 1 → reg_wren=1, w_reg0=8, w_data=0x11111111 after edge 2; alu_ready stays 1 throughout.
- Back-to-back ALU writes to rd=9..12 on consecutive cycles → writes appear on four consecutive cycles in order with no bubbles.
- Contention: ALU (rd=4,0xA) and MEM (rd=5,0xB) accepted on the same edge → ALU written first, MEM next cycle; a repeated pattern alternates MEM then ALU (RR_EN=1).
- Zero-register discard: MEM sends rd=0, data=0xDEADBEEF → accepted (mem_ready=1), reg_wren stays 0, pending stays 0.
- Backpressure: both slots full and MEM keeps asserting valid with new data → mem_ready=0 in the cycle ALU wins; the MEM payload is unchanged when finally written.
- Reset mid-operation: assert reset_n=0 while both slots are full and reg_wren=1 → all outputs 0 immediately; after release no stale write appears and pending=0.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared definitions for the write-back arbiter slice.
// Source IDs, default widths and the hard-wired zero register index.
package wb_pkg;

   localparam int WB_DATA_W = 32;
   localparam int WB_ADDR_W = 5;
   localparam int REG_ZERO  = 0;

   typedef enum logic {
      SRC_ALU = 1'b0,
      SRC_MEM = 1'b1
   } src_e;

endpackage

// File: rtl/wb_slot.sv
// One-entry valid/ready holding register for a single result producer.
// Ports: clk, reset_n, i_valid/o_ready/i_rd/i_data (producer side),
//        i_grant (slot drained this cycle), o_full/o_rd/o_data (held entry).
module wb_slot
   import wb_pkg::*;
#(
   parameter int DATA_W = WB_DATA_W,
   parameter int ADDR_W = WB_ADDR_W
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              i_valid,
   output logic              o_ready,
   input  logic [ADDR_W-1:0] i_rd,
   input  logic [DATA_W-1:0] i_data,
   input  logic              i_grant,
   output logic              o_full,
   output logic [ADDR_W-1:0] o_rd,
   output logic [DATA_W-1:0] o_data
);

   logic              r_full;
   logic [ADDR_W-1:0] r_rd;
   logic [DATA_W-1:0] r_data;
   logic              w_xfer;
   logic              w_load;

   // Draining slot may be refilled on the same edge.
   assign o_ready = !r_full || i_grant;
   assign w_xfer  = i_valid && o_ready;
   // Writes to x0 are accepted but never occupy the slot.
   assign w_load  = w_xfer && (i_rd != ADDR_W'(REG_ZERO));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_full <= 1'b0;
         r_rd   <= '0;
         r_data <= '0;
      end else if (w_load) begin
         r_full <= 1'b1;
         r_rd   <= i_rd;
         r_data <= i_data;
      end else if (i_grant) begin
         r_full <= 1'b0;
      end
   end

   assign o_full = r_full;
   assign o_rd   = r_rd;
   assign o_data = r_data;

endmodule

// File: rtl/wb_arbiter.sv
// Write-back stage: ALU and load slots arbitrated onto one regfile port.
// Ports: clk, reset_n, alu_*/mem_* producer handshakes, reg_wren/w_reg0/
//        w_data registered write port, pending RAW-hazard bitmap.
module wb_arbiter
   import wb_pkg::*;
#(
   parameter int DATA_W = WB_DATA_W,
   parameter int ADDR_W = WB_ADDR_W,
   parameter bit RR_EN  = 1'b1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              alu_valid,
   output logic              alu_ready,
   input  logic [ADDR_W-1:0] alu_rd,
   input  logic [DATA_W-1:0] alu_data,
   input  logic              mem_valid,
   output logic              mem_ready,
   input  logic [ADDR_W-1:0] mem_rd,
   input  logic [DATA_W-1:0] mem_data,
   output logic              reg_wren,
   output logic [ADDR_W-1:0] w_reg0,
   output logic [DATA_W-1:0] w_data,
   output logic [31:0]       pending
);

   logic              w_alu_full;
   logic              w_mem_full;
   logic [ADDR_W-1:0] w_alu_rd;
   logic [ADDR_W-1:0] w_mem_rd;
   logic [DATA_W-1:0] w_alu_dat;
   logic [DATA_W-1:0] w_mem_dat;
   logic              w_alu_gnt;
   logic              w_mem_gnt;
   logic [31:0]       w_pend;
   src_e              r_last;
   logic              r_wren;
   logic [ADDR_W-1:0] r_reg;
   logic [DATA_W-1:0] r_data;

   wb_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_alu (
      .clk     (clk),
      .reset_n (reset_n),
      .i_valid (alu_valid),
      .o_ready (alu_ready),
      .i_rd    (alu_rd),
      .i_data  (alu_data),
      .i_grant (w_alu_gnt),
      .o_full  (w_alu_full),
      .o_rd    (w_alu_rd),
      .o_data  (w_alu_dat)
   );

   wb_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_mem (
      .clk     (clk),
      .reset_n (reset_n),
      .i_valid (mem_valid),
      .o_ready (mem_ready),
      .i_rd    (mem_rd),
      .i_data  (mem_data),
      .i_grant (w_mem_gnt),
      .o_full  (w_mem_full),
      .o_rd    (w_mem_rd),
      .o_data  (w_mem_dat)
   );

   always_comb begin
      w_alu_gnt = 1'b0;
      w_mem_gnt = 1'b0;
      if (w_alu_full && w_mem_full) begin
         if (RR_EN && (r_last == SRC_ALU))
            w_mem_gnt = 1'b1;
         else
            w_alu_gnt = 1'b1;
      end else begin
         w_alu_gnt = w_alu_full;
         w_mem_gnt = w_mem_full;
      end
   end

   // last_grant only tracks contested decisions; a lone slot never
   // steals the next contested turn from the other source.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         r_last <= SRC_MEM;
      else if (w_alu_full && w_mem_full)
         r_last <= w_alu_gnt ? SRC_ALU : SRC_MEM;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wren <= 1'b0;
         r_reg  <= '0;
         r_data <= '0;
      end else if (w_alu_gnt) begin
         r_wren <= 1'b1;
         r_reg  <= w_alu_rd;
         r_data <= w_alu_dat;
      end else if (w_mem_gnt) begin
         r_wren <= 1'b1;
         r_reg  <= w_mem_rd;
         r_data <= w_mem_dat;
      end else begin
         r_wren <= 1'b0;
      end
   end

   always_comb begin
      w_pend = '0;
      for (int i = 1; i < 32; i++) begin
         w_pend[i] = (w_alu_full && (w_alu_rd == ADDR_W'(i)))
                  || (w_mem_full && (w_mem_rd == ADDR_W'(i)))
                  || (r_wren && (r_reg == ADDR_W'(i)));
      end
   end

   assign reg_wren = r_wren;
   assign w_reg0   = r_reg;
   assign w_data   = r_data;
   assign pending  = w_pend;

endmodule

// File: tb/tb_wb_arbiter.sv
// Randomised scoreboard bench for wb_arbiter against a queue-level model.
// Ports: none (top-level bench).
module tb_wb_arbiter;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
   } ent_t;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        alu_valid = 1'b0;
   logic        alu_ready;
   logic [4:0]  alu_rd = '0;
   logic [31:0] alu_data = '0;
   logic        mem_valid = 1'b0;
   logic        mem_ready;
   logic [4:0]  mem_rd = '0;
   logic [31:0] mem_data = '0;
   logic        reg_wren;
   logic [4:0]  w_reg0;
   logic [31:0] w_data;
   logic [31:0] pending;

   int n_checks = 0;
   int n_fail = 0;

   // Reference model: each source owns a queue of at most one entry,
   // sb holds writes the DUT must present on the following cycle.
   ent_t m_alu[$];
   ent_t m_mem[$];
   ent_t sb[$];
   int   m_last = 2;
   bit   a_hold = 0;
   bit   m_hold = 0;

   wb_arbiter #(.DATA_W(32), .ADDR_W(5), .RR_EN(1'b1)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .alu_valid (alu_valid),
      .alu_ready (alu_ready),
      .alu_rd    (alu_rd),
      .alu_data  (alu_data),
      .mem_valid (mem_valid),
      .mem_ready (mem_ready),
      .mem_rd    (mem_rd),
      .mem_data  (mem_data),
      .reg_wren  (reg_wren),
      .w_reg0    (w_reg0),
      .w_data    (w_data),
      .pending   (pending)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // 0 = nobody, 1 = ALU, 2 = MEM
   function automatic int mgrant();
      if (m_alu.size() != 0 && m_mem.size() != 0)
         return (m_last == 1) ? 2 : 1;
      if (m_alu.size() != 0) return 1;
      if (m_mem.size() != 0) return 2;
      return 0;
   endfunction

   task automatic step(input logic av, input logic [4:0] ard,
                       input logic [31:0] ad, input logic mv,
                       input logic [4:0] mrd, input logic [31:0] md);
      int   g;
      bit   ar, mr, both;
      ent_t e;
      @(negedge clk);
      if (!a_hold) begin
         alu_valid = av; alu_rd = ard; alu_data = ad;
      end
      if (!m_hold) begin
         mem_valid = mv; mem_rd = mrd; mem_data = md;
      end
      g  = mgrant();
      ar = (m_alu.size() == 0) || (g == 1);
      mr = (m_mem.size() == 0) || (g == 2);
      @(posedge clk);
      both = (m_alu.size() != 0) && (m_mem.size() != 0);
      if (g == 1) sb.push_back(m_alu.pop_front());
      if (g == 2) sb.push_back(m_mem.pop_front());
      if (both) m_last = g;
      if (alu_valid && ar && alu_rd != 0) begin
         e.rd = alu_rd; e.data = alu_data; m_alu.push_back(e);
      end
      if (mem_valid && mr && mem_rd != 0) begin
         e.rd = mem_rd; e.data = mem_data; m_mem.push_back(e);
      end
      if (m_alu.size() != 0 && m_mem.size() != 0)
         assert (m_alu[0].rd != m_mem[0].rd)
            else $error("both slots hold rd %0d", m_alu[0].rd);
      a_hold = alu_valid && !ar;
      m_hold = mem_valid && !mr;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
   endtask

   // Monitor: compares every cycle away from the active edge.
   initial begin
      int          g;
      logic [31:0] ep;
      ent_t        e;
      forever begin
         @(negedge clk);
         g = mgrant();
         chk("alu_ready", 32'(alu_ready), 32'((m_alu.size() == 0) || g == 1));
         chk("mem_ready", 32'(mem_ready), 32'((m_mem.size() == 0) || g == 2));
         ep = '0;
         if (m_alu.size() != 0) ep[m_alu[0].rd] = 1'b1;
         if (m_mem.size() != 0) ep[m_mem[0].rd] = 1'b1;
         if (sb.size() != 0) ep[sb[0].rd] = 1'b1;
         ep[0] = 1'b0;
         chk("pending", pending, ep);
         chk("reg_wren", 32'(reg_wren), 32'(sb.size() != 0));
         if (sb.size() != 0) begin
            e = sb.pop_front();
            if (reg_wren) begin
               chk("w_reg0", 32'(w_reg0), 32'(e.rd));
               chk("w_data", w_data, e.data);
            end
         end
      end
   end

   initial begin
      logic [4:0] ar, mr;
      #12;
      chk("rst_w_reg0", 32'(w_reg0), 32'h0);
      chk("rst_w_data", w_data, 32'h0);
      chk("rst_wren", 32'(reg_wren), 32'h0);
      @(negedge clk);
      #1 reset_n = 1'b1;

      // single ALU write
      step(1, 8, 32'h11111111, 0, 0, 0);
      idle(3);
      // back-to-back ALU stream
      for (int i = 9; i <= 12; i++)
         step(1, 5'(i), 32'h1000 + 32'(i), 0, 0, 0);
      idle(3);
      // contention, repeated twice to see alternation
      step(1, 4, 32'hA, 1, 5, 32'hB);
      idle(3);
      step(1, 4, 32'hA, 1, 5, 32'hB);
      idle(3);
      // x0 discard
      step(0, 0, 0, 1, 0, 32'hDEADBEEF);
      idle(3);
      // backpressure: MEM keeps offering while ALU wins
      step(1, 2, 32'h21, 1, 3, 32'h31);
      step(1, 6, 32'h22, 1, 7, 32'h32);
      step(1, 8, 32'h23, 1, 9, 32'h33);
      idle(4);

      // reset while both slots are full and a write is on the port
      step(1, 4, 32'hA4, 1, 5, 32'hB5);
      step(1, 6, 32'hA6, 1, 7, 32'hB7);
      #2 reset_n = 1'b0;
      m_alu.delete(); m_mem.delete(); sb.delete();
      m_last = 2; a_hold = 0; m_hold = 0;
      alu_valid = 0; mem_valid = 0;
      #1;
      chk("mid_rst_wren", 32'(reg_wren), 32'h0);
      chk("mid_rst_w_reg0", 32'(w_reg0), 32'h0);
      chk("mid_rst_w_data", w_data, 32'h0);
      chk("mid_rst_pending", pending, 32'h0);
      @(negedge clk);
      #1 reset_n = 1'b1;
      idle(3);

      // randomised traffic, disjoint rd ranges per source
      for (int i = 0; i < 400; i++) begin
         ar = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 15));
         mr = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(16, 31));
         step($urandom_range(0, 3) != 0, ar, $urandom,
              $urandom_range(0, 2) != 0, mr, $urandom);
      end
      a_hold = 0; m_hold = 0;
      idle(5);
      chk("drain_sb", 32'(sb.size()), 32'h0);
      chk("drain_pending", pending, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
